fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have a single clock and one synchronous, active-high reset: clock is clk, reset is rst.
REQ-002 SHALL provide the following ports, one per line:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- stall_in  input  1  downstream (decode/hazard) cannot accept an instruction this cycle
- redirect  input  1  taken branch/jump from execute; wrong-path fetch must be discarded
- redirect_pc  input  16  target PC, valid when redirect=1
- imem_done  input  1  instruction memory returns data this cycle
- imem_data  input  16  instruction word, valid when imem_done=1
- imem_req  output  1  one-cycle read request to instruction memory
- imem_addr  output  16  read address, equal to pc whenever imem_req=1
- instr_valid  output  1  instr_out/pc_out hold a deliverable instruction
- instr_out  output  16  buffered instruction
- pc_out  output  16  PC of instr_out
- pc_plus2  output  16  pc_out+2 modulo 2^16
- halted  output  1  HALT instruction accepted; fetch stopped

Function
REQ-003 SHALL implement four states: FETCH, WAIT, DELIVER, HALT.
REQ-004 SHALL hold a 16-bit pc register, a 16-bit instruction buffer, a 16-bit buffered-PC register, a pending-redirect flag and a 16-bit pending-target register.
REQ-005 FETCH, redirect=0: imem_req=1, imem_addr=pc, next state WAIT.
REQ-006 FETCH, redirect=1: imem_req=0, pc<=redirect_pc, stay FETCH.
REQ-007 WAIT: imem_req=0; imem_done=0 keeps WAIT, no memory-latency bound.
REQ-008 WAIT, redirect=1 without imem_done: pending flag set, pending target<=redirect_pc; a later redirect overwrites the target (last wins).
REQ-009 WAIT, imem_done=1, no pending flag and redirect=0: buffer<=imem_data, buffered-PC<=pc, next DELIVER.
REQ-010 WAIT, imem_done=1 with pending flag set or redirect=1 the same cycle: data discarded; pc<=redirect_pc if redirect=1, else pending target; pending flag cleared; next FETCH.
REQ-011 DELIVER: instr_valid=1, instr_out=buffer, pc_out=buffered-PC; imem_req=0.
REQ-012 DELIVER, stall_in=1, redirect=0: all state held, instr_valid stays 1.
REQ-013 DELIVER, stall_in=0, redirect=0 accepts the instruction; if buffer[15:11]=5'b00000 (HALT) then next HALT with pc unchanged, else pc<=pc+2, next FETCH.
REQ-014 DELIVER, redirect=1 (any stall_in): buffered instruction dropped, pc<=redirect_pc, next FETCH; instr_valid=0 next cycle.
REQ-015 HALT: halted=1, imem_req=0, instr_valid=0; redirect, stall_in and imem_done ignored; exit only via rst.
REQ-016 pc+2 and pc_plus2 SHALL wrap modulo 2^16 (0xFFFE -> 0x0000); redirect_pc loaded unmodified, including bit 0.
REQ-017 Latency with no stall/redirect: req cycle t, imem_done cycle t+k (k>=1), instr_valid from t+k+1, next imem_req at t+k+2.
REQ-018 imem_done outside WAIT SHALL be ignored.
REQ-019 SHALL hold at most one outstanding memory request.

Reset
REQ-020 On rst=1 at a clock edge: state FETCH, pc=0x0000, buffer=0x0000, buffered-PC=0x0000, pending flag=0, pending target=0x0000.
REQ-021 While rst=1 SHALL drive imem_req=0, instr_valid=0, halted=0, instr_out=0x0000, pc_out=0x0000; pc_plus2 follows REQ-016.
REQ-022 rst SHALL take priority over all inputs in any state, including mid-WAIT and HALT; a stale imem_done after reset arriving in FETCH is ignored (REQ-018).
REQ-023 First cycle after rst deasserts: imem_req=1, imem_addr=0x0000.

Verification
REQ-024 Sequential fetch, k=2, stall_in=0, data 0x4000,0x4100 -> imem_addr 0x0000 then 0x0002; instr_valid pulses with pc_out 0x0000 then 0x0002, pc_plus2 0x0002 then 0x0004.
REQ-025 Stall hold: DELIVER with instr 0x1234, stall_in=1 for 3 cycles -> instr_valid=1 and instr_out=0x1234 stable for 4 cycles, no imem_req until stall_in=0.
REQ-026 Redirect mid-WAIT: redirect=1, redirect_pc=0x0100, then 0x0200 two cycles later, imem_done after that -> no instr_valid; next imem_addr=0x0200.
REQ-027 Redirect same cycle as imem_done, and in DELIVER with stall_in=1, redirect_pc=0x0040 -> instruction dropped; next imem_addr=0x0040.
REQ-028 HALT: fetched 0x0000 at pc 0x0006, accepted -> halted=1 permanently, no further imem_req, redirect ignored; rst -> halted=0, imem_addr=0x0000.
REQ-029 Wrap and reset: redirect to 0xFFFE, accept non-HALT -> next imem_addr=0x0000; rst asserted in WAIT -> FETCH at 0x0000 next cycle, late imem_done ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer.
// Issues one read at a time, buffers the returned word until decode takes it,
// and honours execute-stage redirects. A redirect that arrives while a read is
// in flight is remembered, so the late data is thrown away.
module fetch_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              imem_done,
  input  logic [DATA_W-1:0] imem_data,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pc_plus2,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  // Next sequential PC; wraps naturally at the top of the address space.
  function automatic logic [DATA_W-1:0] inc2(input logic [DATA_W-1:0] a);
    return a + DATA_W'(2);
  endfunction

  // HALT is any word whose opcode field (top five bits) is zero.
  function automatic logic is_halt(input logic [DATA_W-1:0] w);
    return (w[DATA_W-1 -: 5] == 5'b00000);
  endfunction

  state_t            state_p0;
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] instr_buf_p0;
  logic [DATA_W-1:0] buf_pc_p0;
  logic              pend_vld_p0;
  logic [DATA_W-1:0] pend_pc_p0;

  // ---- stage p0: fetch sequencer state ----
  // Sequencer: request, wait for memory, hold the word for decode, or stop on HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= S_FETCH;
      pc_p0        <= '0;
      instr_buf_p0 <= '0;
      buf_pc_p0    <= '0;
      pend_vld_p0  <= 1'b0;
      pend_pc_p0   <= '0;
    end else begin
      case (state_p0)
        S_FETCH: begin
          if (redirect) begin
            pc_p0 <= redirect_pc;
          end else begin
            state_p0 <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_done) begin
            if (pend_vld_p0 || redirect) begin
              // Wrong-path data: drop it and restart at the newest target.
              pc_p0       <= redirect ? redirect_pc : pend_pc_p0;
              pend_vld_p0 <= 1'b0;
              state_p0    <= S_FETCH;
            end else begin
              instr_buf_p0 <= imem_data;
              buf_pc_p0    <= pc_p0;
              state_p0     <= S_DELIVER;
            end
          end else if (redirect) begin
            // Read still in flight; last redirect before the data wins.
            pend_vld_p0 <= 1'b1;
            pend_pc_p0  <= redirect_pc;
          end
        end
        S_DELIVER: begin
          if (redirect) begin
            pc_p0    <= redirect_pc;
            state_p0 <= S_FETCH;
          end else if (!stall_in) begin
            if (is_halt(instr_buf_p0)) begin
              state_p0 <= S_HALT;
            end else begin
              pc_p0    <= inc2(pc_p0);
              state_p0 <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_p0 <= S_HALT;
        end
        default: begin
          state_p0 <= S_FETCH;
        end
      endcase
    end
  end

  // ---- outputs: decoded from stage p0, forced quiet while reset is held ----
  assign imem_req    = !rst && (state_p0 == S_FETCH) && !redirect;
  assign imem_addr   = pc_p0;
  assign instr_valid = !rst && (state_p0 == S_DELIVER);
  assign instr_out   = rst ? '0 : instr_buf_p0;
  assign pc_out      = rst ? '0 : buf_pc_p0;
  assign pc_plus2    = inc2(pc_out);
  assign halted      = !rst && (state_p0 == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized stimulus against a transaction-level fetch model.
// The driver advances the model each cycle and queues the requests, deliveries
// and halt cycles it expects; an independent monitor pops and compares them
// whenever the DUT presents the corresponding output.
module tb_fetch_ctrl;

  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;

  fetch_ctrl #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_plus2    (pc_plus2),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } rec_t;

  rec_t req_q[$];
  rec_t dlv_q[$];
  rec_t hlt_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run_done = 1'b0;

  // Transaction-level model: where the next fetch goes, whether a read is
  // owed by memory, whether an instruction is waiting for decode, and
  // whether a redirect is owed to the in-flight read.
  bit          m_halt, m_busy, m_have, m_owed;
  logic [15:0] m_pc, m_ins, m_ipc, m_owed_pc;
  int          mem_cnt, halt_age;

  task automatic model_step();
    if (rst) begin
      m_halt = 0; m_busy = 0; m_have = 0; m_owed = 0;
      m_pc = 16'h0000; m_ins = 16'h0000; m_ipc = 16'h0000; m_owed_pc = 16'h0000;
      halt_age = 0;
    end else if (m_halt) begin
      hlt_q.push_back(rec_t'{cyc, 16'h0, 16'h0, 16'h0});
      halt_age++;
    end else if (m_have) begin
      dlv_q.push_back(rec_t'{cyc, m_ins, m_ipc, 16'(m_ipc + 16'd2)});
      if (redirect) begin
        m_have = 0;
        m_pc = redirect_pc;
      end else if (!stall_in) begin
        m_have = 0;
        if (m_ins[15:11] == 5'b00000) m_halt = 1;
        else m_pc = 16'(m_pc + 16'd2);
      end
    end else if (m_busy) begin
      if (imem_done) begin
        m_busy = 0;
        if (redirect || m_owed) begin
          m_pc = redirect ? redirect_pc : m_owed_pc;
          m_owed = 0;
        end else begin
          m_have = 1;
          m_ins = imem_data;
          m_ipc = m_pc;
        end
      end else if (redirect) begin
        m_owed = 1;
        m_owed_pc = redirect_pc;
      end
    end else begin
      if (redirect) begin
        m_pc = redirect_pc;
      end else begin
        req_q.push_back(rec_t'{cyc, m_pc, 16'h0, 16'h0});
        m_busy = 1;
        mem_cnt = $urandom_range(1, 3);
      end
    end
  endtask

  // Driver: random inputs on the falling edge, memory responder follows the model.
  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_done = 1'b0; imem_data = 16'h0000;
    m_halt = 0; m_busy = 0; m_have = 0; m_owed = 0;
    m_pc = 16'h0; m_ins = 16'h0; m_ipc = 16'h0; m_owed_pc = 16'h0;
    mem_cnt = 0; halt_age = 0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      cyc++;
      rst = (n < 2) || ($urandom_range(0, 199) == 0) || (m_halt && halt_age > 6);
      stall_in = ($urandom_range(0, 99) < 40);
      redirect = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFE;
      else redirect_pc = 16'($urandom);
      if (m_busy) begin
        mem_cnt--;
        imem_done = (mem_cnt <= 0);
      end else begin
        imem_done = ($urandom_range(0, 9) == 0);
      end
      imem_data = 16'($urandom);
      if ($urandom_range(0, 99) < 4) imem_data[15:11] = 5'b00000;
      else if (imem_data[15:11] == 5'b00000) imem_data[15] = 1'b1;
      model_step();
    end
    #3;
    run_done = 1'b1;
    #10;
    while (req_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL req_missing cyc=%0d got none required addr %h", req_q[0].cyc, req_q[0].a);
      void'(req_q.pop_front());
    end
    while (dlv_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL deliver_missing cyc=%0d got none required instr %h pc %h", dlv_q[0].cyc, dlv_q[0].a, dlv_q[0].b);
      void'(dlv_q.pop_front());
    end
    while (hlt_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL halted_missing cyc=%0d got 0 required 1", hlt_q[0].cyc);
      void'(hlt_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: samples 2ns after the falling edge, well away from the rising edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (run_done) break;

      if (rst) begin
        checks++;
        if (imem_req || instr_valid || halted || instr_out != 16'h0 || pc_out != 16'h0 || pc_plus2 != 16'h0002) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got req=%b vld=%b hlt=%b instr=%h pc=%h pc2=%h required 0 0 0 0000 0000 0002",
                   cyc, imem_req, instr_valid, halted, instr_out, pc_out, pc_plus2);
        end
      end

      while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL req_missing cyc=%0d got none required addr %h", req_q[0].cyc, req_q[0].a);
        void'(req_q.pop_front());
      end
      while (dlv_q.size() > 0 && dlv_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL deliver_missing cyc=%0d got none required instr %h pc %h", dlv_q[0].cyc, dlv_q[0].a, dlv_q[0].b);
        void'(dlv_q.pop_front());
      end
      while (hlt_q.size() > 0 && hlt_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL halted_missing cyc=%0d got 0 required 1", hlt_q[0].cyc);
        void'(hlt_q.pop_front());
      end

      if (imem_req) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected cyc=%0d got addr %h required no request", cyc, imem_addr);
        end else begin
          r = req_q.pop_front();
          if (r.cyc != cyc || r.a != imem_addr) begin
            errors++;
            $display("FAIL req_addr cyc=%0d got addr %h required addr %h at cyc %0d", cyc, imem_addr, r.a, r.cyc);
          end
        end
      end

      if (instr_valid) begin
        checks++;
        if (dlv_q.size() == 0) begin
          errors++;
          $display("FAIL deliver_unexpected cyc=%0d got instr %h pc %h required no instr_valid", cyc, instr_out, pc_out);
        end else begin
          r = dlv_q.pop_front();
          if (r.cyc != cyc || r.a != instr_out || r.b != pc_out || r.c != pc_plus2) begin
            errors++;
            $display("FAIL deliver cyc=%0d got instr %h pc %h pc2 %h required instr %h pc %h pc2 %h at cyc %0d",
                     cyc, instr_out, pc_out, pc_plus2, r.a, r.b, r.c, r.cyc);
          end
        end
      end

      if (halted) begin
        checks++;
        if (hlt_q.size() == 0) begin
          errors++;
          $display("FAIL halted_unexpected cyc=%0d got 1 required 0", cyc);
        end else begin
          r = hlt_q.pop_front();
          if (r.cyc != cyc) begin
            errors++;
            $display("FAIL halted_timing cyc=%0d got halted required at cyc %0d", cyc, r.cyc);
          end
        end
      end
    end
  end

endmodule
